user_ddr_arbiter: RTL and testbench
===================================

# user_ddr_arbiter

Round-robin arbiter that shares the single user-logic DDR port (256-bit data, 27-bit address, active-low byte enables) between N requesters inside user logic. Each requester issues single-beat reads or writes through a request/ack handshake. The arbiter serialises them onto the DDR port and routes read data back to the issuing requester. It sits between user compute engines and the DDR port of the user-logic wrapper, in the DDR clock domain.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2–8).

Ports:
- i_ddr_clk  in  1  single clock (200 MHz); everything synchronous to it.
- i_rst  in  1  reset; synchronous, active-high.
- i_req_rd  in  NUM_REQ  per-requester read request; held until o_req_ack.
- i_req_wr  in  NUM_REQ  per-requester write request; held until o_req_ack.
- i_req_addr  in  NUM_REQ*27  per-requester address; slice k = [27k+26:27k].
- i_req_wr_data  in  NUM_REQ*256  per-requester write data.
- i_req_wr_be_n  in  NUM_REQ*32  per-requester active-low byte enables.
- o_req_ack  out  NUM_REQ  one-cycle pulse: the request has been captured.
- o_req_rd_data  out  256  read data, shared by all requesters.
- o_req_rd_valid  out  NUM_REQ  one-cycle pulse to the owner when o_req_rd_data is valid.
- o_ddr_addr  out  27  DDR address.
- o_ddr_rd  out  1  read command; held until i_ddr_rd_ack.
- o_ddr_wr_data  out  256  write data.
- o_ddr_wr_data_be_n  out  32  write byte enables.
- o_ddr_wr_data_valid  out  1  write command; held until i_ddr_wr_ack.
- i_ddr_rd_data  in  256  returned read data.
- i_ddr_rd_data_valid  in  1  read data strobe.
- i_ddr_wr_ack  in  1  write accepted.
- i_ddr_rd_ack  in  1  read command accepted.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no transaction in progress.
  - WR: drive the write command until i_ddr_wr_ack.
  - RD_CMD: drive the read command until i_ddr_rd_ack.
  - RD_DATA: wait for i_ddr_rd_data_valid.
- Requests:
  - Requester k is requesting when i_req_rd[k] or i_req_wr[k] is high.
  - If both are high, the write is served first. The read stays pending and competes in a later arbitration.
- Arbitration happens in IDLE only:
  - Round-robin over the requesting set, searching from last_grant+1 upward with wrap.
  - On reset, last_grant = NUM_REQ-1, so requester 0 has first priority.
- On grant of k:
  - Capture addr, wr_data and be_n of slice k into registers, record owner = k, set last_grant = k.
  - Pulse o_req_ack[k].
  - Enter WR or RD_CMD.
- DDR outputs:
  - DDR command outputs are driven only from the captured registers.
  - Requester inputs may change after ack without effect.
- Write completion:
  - WR → IDLE on i_ddr_wr_ack.
  - o_ddr_wr_data_valid deasserts the following cycle.
- Read command and data:
  - RD_CMD → RD_DATA on i_ddr_rd_ack.
  - If i_ddr_rd_data_valid is high in the same cycle as i_ddr_rd_ack, the data is accepted and the state goes directly to IDLE.
  - RD_DATA → IDLE on i_ddr_rd_data_valid. i_ddr_rd_data is registered into o_req_rd_data, and o_req_rd_valid[owner] pulses on the next cycle.
- Only one transaction is outstanding at any time. No read/write reordering is possible.
- Ignored inputs:
  - i_ddr_rd_data_valid outside RD_CMD/RD_DATA; o_req_rd_data and o_req_rd_valid are unchanged.
  - i_ddr_wr_ack outside WR.
  - i_ddr_rd_ack outside RD_CMD.
- Reset mid-transaction:
  - The transaction is dropped and no ack or rd_valid is produced.
  - The DDR controller is reset by the same system reset.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM_REQ-1.
  - o_req_ack, o_req_rd_valid, o_ddr_rd, o_ddr_wr_data_valid, o_busy = 0.
  - o_ddr_addr, o_ddr_wr_data, o_req_rd_data = 0; o_ddr_wr_data_be_n = all ones.
- Grant latency:
  - Request seen in IDLE at edge t → o_req_ack[k], command strobe and o_busy all high after edge t+1.
  - o_req_ack is high for exactly one cycle.
- Write completion: i_ddr_wr_ack sampled at edge u → command low and IDLE after u+1 → next grant after u+2 at the earliest.
  - This gives a 1-cycle bubble between transactions.
- Read data return: i_ddr_rd_data_valid at edge v → o_req_rd_valid[owner] and o_req_rd_data after v+1, IDLE after v+1.
- Re-request by the same requester: a requester that deasserts after ack and re-requests immediately is served no earlier than the bubble allows. Round-robin passes priority to others first if they are requesting.

## Structure
- Package user_ddr_arb_pkg:
  - DDR_ADDR_W = 27, DDR_DATA_W = 256, DDR_BE_W = 32.
  - State enum {IDLE, WR, RD_CMD, RD_DATA}.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ; inputs req vector, last_grant pointer.
  - Outputs one-hot grant and grant index, combinational.
  - Unit-testable alone.
- The top level holds the FSM, capture registers, owner register and read-return path.

## Test plan
- Single write: requester 2 requests wr with addr 0x1234, i_ddr_wr_ack 3 cycles later.
  - Required: o_req_ack[2] 1 cycle after the request; o_ddr_wr_data_valid high 3 cycles with addr 0x1234, then low.
- Single read: requester 1 reads, rd_ack after 2 cycles, data 0xA5… 5 cycles later.
  - Required: o_req_rd_valid = 4'b0010 for one cycle with that data.
- Fairness: all 4 requesters hold wr requests, zero-latency wr_ack.
  - Required: grant order 0, 1, 2, 3, 0, …; each ack separated by 2 cycles.
- Same-cycle return: i_ddr_rd_ack and i_ddr_rd_data_valid in the same cycle.
  - Required: rd_valid the next cycle; o_busy low the next cycle.
- Precedence and stray strobes: requester 0 asserts rd and wr together; a spurious i_ddr_rd_data_valid arrives during WR.
  - Required: write served first, read granted afterwards; no o_req_rd_valid pulse from the stray strobe.
- Reset mid-read: i_rst asserted in RD_DATA.
  - Required: all outputs at reset values next cycle; a later i_ddr_rd_data_valid produces no rd_valid.

Source files
------------

// File: rtl/user_ddr_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | user_ddr_arb_pkg                                                      |
// | DDR port widths and arbiter state encoding.                           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package user_ddr_arb_pkg;

  localparam int DDR_ADDR_W = 27;
  localparam int DDR_DATA_W = 256;
  localparam int DDR_BE_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_CMD  = 2'd2,
    RD_DATA = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/user_ddr_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | user_ddr_arbiter_if                                                   |
// | Requester-side and DDR-side signals of the arbiter.                   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface user_ddr_arbiter_if
  import user_ddr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]            i_req_rd;
  logic [NUM_REQ-1:0]            i_req_wr;
  logic [NUM_REQ*DDR_ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ*DDR_DATA_W-1:0] i_req_wr_data;
  logic [NUM_REQ*DDR_BE_W-1:0]   i_req_wr_be_n;
  logic [NUM_REQ-1:0]            o_req_ack;
  logic [DDR_DATA_W-1:0]         o_req_rd_data;
  logic [NUM_REQ-1:0]            o_req_rd_valid;
  logic [DDR_ADDR_W-1:0]         o_ddr_addr;
  logic                          o_ddr_rd;
  logic [DDR_DATA_W-1:0]         o_ddr_wr_data;
  logic [DDR_BE_W-1:0]           o_ddr_wr_data_be_n;
  logic                          o_ddr_wr_data_valid;
  logic [DDR_DATA_W-1:0]         i_ddr_rd_data;
  logic                          i_ddr_rd_data_valid;
  logic                          i_ddr_wr_ack;
  logic                          i_ddr_rd_ack;
  logic                          o_busy;

  // Arbiter view
  modport master (
    input  i_req_rd, i_req_wr, i_req_addr, i_req_wr_data, i_req_wr_be_n,
    input  i_ddr_rd_data, i_ddr_rd_data_valid, i_ddr_wr_ack, i_ddr_rd_ack,
    output o_req_ack, o_req_rd_data, o_req_rd_valid,
    output o_ddr_addr, o_ddr_rd, o_ddr_wr_data, o_ddr_wr_data_be_n,
    output o_ddr_wr_data_valid, o_busy
  );

  // Requesters plus DDR controller view
  modport slave (
    output i_req_rd, i_req_wr, i_req_addr, i_req_wr_data, i_req_wr_be_n,
    output i_ddr_rd_data, i_ddr_rd_data_valid, i_ddr_wr_ack, i_ddr_rd_ack,
    input  o_req_ack, o_req_rd_data, o_req_rd_valid,
    input  o_ddr_addr, o_ddr_rd, o_ddr_wr_data, o_ddr_wr_data_be_n,
    input  o_ddr_wr_data_valid, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/user_ddr_arbiter_rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arbiter                                                            |
// | Combinational round-robin pick, searching upward from last_grant+1.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

  logic [IDX_W-1:0] w_pos;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_pos         = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_pos = IDX_W'((int'(i_last_grant) + off) % NUM_REQ);
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_grant_idx    = w_pos;
        o_grant_valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/user_ddr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | user_ddr_arbiter                                                      |
// | Round-robin sharing of one DDR port among NUM_REQ single-beat users.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module user_ddr_arbiter
  import user_ddr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               i_ddr_clk,
  input  logic               i_rst,
  user_ddr_arbiter_if.master bus
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    w_req;
  logic [NUM_REQ-1:0]    w_grant;
  logic [c_IDX_W-1:0]    w_grant_idx;
  logic                  w_grant_valid;

  state_t                r_state;
  logic [c_IDX_W-1:0]    r_last_grant;
  logic [c_IDX_W-1:0]    r_owner;
  logic [DDR_ADDR_W-1:0] r_addr;
  logic [DDR_DATA_W-1:0] r_wr_data;
  logic [DDR_BE_W-1:0]   r_be_n;
  logic                  r_ddr_rd;
  logic                  r_ddr_wr_vld;
  logic [NUM_REQ-1:0]    r_req_ack;
  logic [NUM_REQ-1:0]    r_rd_valid;
  logic [DDR_DATA_W-1:0] r_rd_data;

  assign w_req = bus.i_req_rd | bus.i_req_wr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_arbiter (
    .i_req         (w_req),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_grant),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_last_grant <= c_IDX_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_be_n       <= '1;
      r_ddr_rd     <= 1'b0;
      r_ddr_wr_vld <= 1'b0;
      r_req_ack    <= '0;
      r_rd_valid   <= '0;
      r_rd_data    <= '0;
    end else begin
      r_req_ack  <= '0;
      r_rd_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_addr       <= bus.i_req_addr[int'(w_grant_idx)*DDR_ADDR_W +: DDR_ADDR_W];
            r_wr_data    <= bus.i_req_wr_data[int'(w_grant_idx)*DDR_DATA_W +: DDR_DATA_W];
            r_be_n       <= bus.i_req_wr_be_n[int'(w_grant_idx)*DDR_BE_W +: DDR_BE_W];
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_req_ack    <= w_grant;
            // A simultaneous read stays pending and re-arbitrates later.
            if (bus.i_req_wr[w_grant_idx]) begin
              r_state      <= WR;
              r_ddr_wr_vld <= 1'b1;
            end else begin
              r_state  <= RD_CMD;
              r_ddr_rd <= 1'b1;
            end
          end
        end
        WR: begin
          if (bus.i_ddr_wr_ack) begin
            r_state      <= IDLE;
            r_ddr_wr_vld <= 1'b0;
          end
        end
        RD_CMD: begin
          if (bus.i_ddr_rd_data_valid) begin
            r_state             <= IDLE;
            r_ddr_rd            <= 1'b0;
            r_rd_data           <= bus.i_ddr_rd_data;
            r_rd_valid[r_owner] <= 1'b1;
          end else if (bus.i_ddr_rd_ack) begin
            r_state  <= RD_DATA;
            r_ddr_rd <= 1'b0;
          end
        end
        RD_DATA: begin
          if (bus.i_ddr_rd_data_valid) begin
            r_state             <= IDLE;
            r_rd_data           <= bus.i_ddr_rd_data;
            r_rd_valid[r_owner] <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ack           = r_req_ack;
  assign bus.o_req_rd_data       = r_rd_data;
  assign bus.o_req_rd_valid      = r_rd_valid;
  assign bus.o_ddr_addr          = r_addr;
  assign bus.o_ddr_rd            = r_ddr_rd;
  assign bus.o_ddr_wr_data       = r_wr_data;
  assign bus.o_ddr_wr_data_be_n  = r_be_n;
  assign bus.o_ddr_wr_data_valid = r_ddr_wr_vld;
  assign bus.o_busy              = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_user_ddr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_user_ddr_arbiter                                                   |
// | Directed per-cycle vectors plus a mid-read reset sequence.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_user_ddr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  user_ddr_arbiter_if #(.NUM_REQ(4)) bus ();

  user_ddr_arbiter #(.NUM_REQ(4)) dut (
    .i_ddr_clk (clk),
    .i_rst     (rst),
    .bus       (bus)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        wr_ack;
    logic        rd_ack;
    logic        rd_dv;
    logic [31:0] rdd_in;
    logic [3:0]  e_ack;
    logic [3:0]  e_rdv;
    logic [1:0]  e_cmd;   // {wr_data_valid, rd}
    logic        e_busy;
    logic [26:0] e_addr;
    logic [31:0] e_rdd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [26:0] req_addr(input int k);
    return 27'h1232 + 27'(k);
  endfunction

  function automatic logic [255:0] req_wdata(input int k);
    return {8{32'hD000_0000 + 32'(k)}};
  endfunction

  function automatic logic [31:0] req_ben(input int k);
    return ~(32'h1 << k);
  endfunction

  function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr,
                              input logic wa, input logic ra, input logic dv,
                              input logic [31:0] rdd_in, input logic [3:0] e_ack,
                              input logic [3:0] e_rdv, input logic [1:0] e_cmd,
                              input logic e_busy, input logic [26:0] e_addr,
                              input logic [31:0] e_rdd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.wr_ack = wa; v.rd_ack = ra; v.rd_dv = dv;
    v.rdd_in = rdd_in; v.e_ack = e_ack; v.e_rdv = e_rdv; v.e_cmd = e_cmd;
    v.e_busy = e_busy; v.e_addr = e_addr; v.e_rdd = e_rdd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rd, input logic [3:0] wr, input logic wa,
                       input logic ra, input logic dv, input logic [31:0] rdd);
    bus.i_req_rd            = rd;
    bus.i_req_wr            = wr;
    bus.i_ddr_wr_ack        = wa;
    bus.i_ddr_rd_ack        = ra;
    bus.i_ddr_rd_data_valid = dv;
    bus.i_ddr_rd_data       = {8{rdd}};
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ack"},  256'(bus.o_req_ack), 256'(4'b0));
    chk({tag, " rdv"},  256'(bus.o_req_rd_valid), 256'(4'b0));
    chk({tag, " cmd"},  256'({bus.o_ddr_wr_data_valid, bus.o_ddr_rd}), 256'(2'b00));
    chk({tag, " busy"}, 256'(bus.o_busy), 256'(1'b0));
    chk({tag, " addr"}, 256'(bus.o_ddr_addr), 256'(27'h0));
    chk({tag, " wdata"}, bus.o_ddr_wr_data, 256'h0);
    chk({tag, " be_n"}, 256'(bus.o_ddr_wr_data_be_n), 256'(32'hFFFF_FFFF));
    chk({tag, " rdata"}, bus.o_req_rd_data, 256'h0);
  endtask

  localparam logic [26:0] A0 = 27'h1232;
  localparam logic [26:0] A1 = 27'h1233;
  localparam logic [26:0] A2 = 27'h1234;
  localparam logic [26:0] A3 = 27'h1235;
  localparam logic [31:0] DA5 = 32'hA5A5_A5A5;
  localparam logic [31:0] D3C = 32'h3C3C_3C3C;
  localparam logic [31:0] D5A = 32'h5A5A_5A5A;

  initial begin
    for (int k = 0; k < 4; k++) begin
      bus.i_req_addr[k*27 +: 27]     = req_addr(k);
      bus.i_req_wr_data[k*256 +: 256] = req_wdata(k);
      bus.i_req_wr_be_n[k*32 +: 32]  = req_ben(k);
    end
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Fairness: all write, controller acks immediately.
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h1, 4'h0, 2'b10, 1, A0, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A0, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h2, 4'h0, 2'b10, 1, A1, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A1, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h4, 4'h0, 2'b10, 1, A2, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A2, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h8, 4'h0, 2'b10, 1, A3, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A3, 0));
    vecs.push_back(mk(4'h0, 4'hF, 1, 0, 0, 0, 4'h1, 4'h0, 2'b10, 1, A0, 0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A0, 0));
    // Single write from requester 2, ack three cycles later.
    vecs.push_back(mk(4'h0, 4'h4, 0, 0, 0, 0, 4'h4, 4'h0, 2'b10, 1, A2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b10, 1, A2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b10, 1, A2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A2, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A2, 0));
    // Single read from requester 1.
    vecs.push_back(mk(4'h2, 4'h0, 0, 0, 0, 0, 4'h2, 4'h0, 2'b01, 1, A1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b01, 1, A1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h0, 2'b00, 1, A1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, A1, 0));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 1, DA5, 4'h0, 4'h2, 2'b00, 0, A1, DA5));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A1, DA5));
    // Same-cycle rd_ack and data from requester 3.
    vecs.push_back(mk(4'h8, 4'h0, 0, 0, 0, 0, 4'h8, 4'h0, 2'b01, 1, A3, DA5));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 1, D3C, 4'h0, 4'h8, 2'b00, 0, A3, D3C));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A3, D3C));
    // Requester 0 rd+wr together; stray data strobe during WR and in IDLE.
    vecs.push_back(mk(4'h1, 4'h1, 0, 0, 0, 0, 4'h1, 4'h0, 2'b10, 1, A0, D3C));
    vecs.push_back(mk(4'h1, 4'h0, 0, 0, 1, 32'hFFFF_0000, 4'h0, 4'h0, 2'b10, 1, A0, D3C));
    vecs.push_back(mk(4'h1, 4'h0, 1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, A0, D3C));
    vecs.push_back(mk(4'h1, 4'h0, 0, 0, 0, 0, 4'h1, 4'h0, 2'b01, 1, A0, D3C));
    vecs.push_back(mk(4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h0, 2'b00, 1, A0, D3C));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 1, D5A, 4'h0, 4'h1, 2'b00, 0, A0, D5A));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 1, 32'h1111_1111, 4'h0, 4'h0, 2'b00, 0, A0, D5A));

    rst = 1'b1;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].wr_ack, vecs[i].rd_ack, vecs[i].rd_dv, vecs[i].rdd_in);
      tick();
      chk($sformatf("v%0d ack", i), 256'(bus.o_req_ack), 256'(vecs[i].e_ack));
      chk($sformatf("v%0d rdv", i), 256'(bus.o_req_rd_valid), 256'(vecs[i].e_rdv));
      chk($sformatf("v%0d cmd", i), 256'({bus.o_ddr_wr_data_valid, bus.o_ddr_rd}), 256'(vecs[i].e_cmd));
      chk($sformatf("v%0d busy", i), 256'(bus.o_busy), 256'(vecs[i].e_busy));
      chk($sformatf("v%0d addr", i), 256'(bus.o_ddr_addr), 256'(vecs[i].e_addr));
      chk($sformatf("v%0d rdata", i), bus.o_req_rd_data, {8{vecs[i].e_rdd}});
      if (vecs[i].e_cmd == 2'b10) begin
        chk($sformatf("v%0d wdata", i), bus.o_ddr_wr_data,
            req_wdata(int'(vecs[i].e_addr - 27'h1232)));
        chk($sformatf("v%0d be_n", i), 256'(bus.o_ddr_wr_data_be_n),
            256'(req_ben(int'(vecs[i].e_addr - 27'h1232))));
      end
    end

    // Reset while a read waits for data from requester 2.
    drive(4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mr ack", 256'(bus.o_req_ack), 256'(4'h4));
    chk("mr rd cmd", 256'(bus.o_ddr_rd), 256'(1'b1));
    drive(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    bus.i_req_addr[2*27 +: 27] = 27'h7777;
    tick();
    chk("mr addr held", 256'(bus.o_ddr_addr), 256'(A2));
    chk("mr busy", 256'(bus.o_busy), 256'(1'b1));
    bus.i_req_addr[2*27 +: 27] = req_addr(2);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    chk_reset("mr reset");
    rst = 1'b0;
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h9999_9999);
    tick();
    chk("mr late rdv", 256'(bus.o_req_rd_valid), 256'(4'h0));
    chk("mr late rdata", bus.o_req_rd_data, 256'h0);
    chk("mr late busy", 256'(bus.o_busy), 256'(1'b0));
    drive(4'h0, 4'h9, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mr prio ack", 256'(bus.o_req_ack), 256'(4'h1));
    chk("mr prio addr", 256'(bus.o_ddr_addr), 256'(A0));
    drive(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mr prio done", 256'({bus.o_ddr_wr_data_valid, bus.o_busy}), 256'(2'b00));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
